// File: rtl/spi_link_pkg.sv
// Shared types, header layout and TX word builder for the SPI link controller.
package spi_link_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } tx_state_e;

  localparam int HDR_W         = 8;
  localparam int HDR_VALID_BIT = 7;
  localparam int ID_LSB        = 0;
  localparam int ID_W          = 4;
  localparam int MAX_W         = 256;

  // Header byte sits at the top of a data_w-bit frame; payload is already zero-extended.
  function automatic logic [MAX_W-1:0] make_tx_word(input logic [ID_W-1:0]  id,
                                                    input logic [MAX_W-1:0] payload,
                                                    input int               data_w);
    logic [HDR_W-1:0] hdr;
    logic [MAX_W-1:0] hdr_ext;
    hdr                     = '0;
    hdr[HDR_VALID_BIT]      = 1'b1;
    hdr[ID_LSB +: ID_W]     = id;
    hdr_ext                 = MAX_W'(hdr);
    return (hdr_ext << (data_w - HDR_W)) | payload;
  endfunction

endpackage

// File: rtl/spi_link_ctrl_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on advance.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;
  logic          found;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_q) + i) % N);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        idx_o          = cand;
        grant_o[cand]  = 1'b1;
      end
    end
    any_o = found;
  end

  // NOTE: sequential state uses non-blocking assignments; blocking ones here would race readers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance_i && found) begin
      ptr_q <= (int'(idx_o) == N - 1) ? '0 : idx_o + IW'(1);
    end
  end

endmodule

// File: rtl/spi_link_ctrl.sv
// System-clock side of the SPI slave link: frame detection, RX queue and arbitrated TX word.
module spi_link_ctrl
  import spi_link_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                N_REQ     = 4,
  parameter int                RX_DEPTH  = 4,
  parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             spi_data_in,
  input  logic                          spi_ready,
  input  logic                          spi_cs,
  output logic [DATA_W-1:0]             spi_data_out,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*(DATA_W-8)-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          rx_valid,
  output logic [DATA_W-1:0]             rx_data,
  input  logic                          rx_ready,
  output logic                          rx_overflow,
  input  logic                          ovf_clr,
  output logic [15:0]                   frame_cnt
);

  localparam int PAY_W = DATA_W - HDR_W;
  localparam int PTR_W = $clog2(RX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ARB_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic ready_s1_q, ready_s2_q, ready_s3_q;
  logic cs_s1_q, cs_s2_q;
  logic frame_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_s1_q <= 1'b0;
      ready_s2_q <= 1'b0;
      ready_s3_q <= 1'b0;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
    end else begin
      ready_s1_q <= spi_ready;
      ready_s2_q <= ready_s1_q;
      ready_s3_q <= ready_s2_q;
      cs_s1_q    <= spi_cs;
      cs_s2_q    <= cs_s1_q;
    end
  end

  // The data bus is held stable by the shifter long after data_ready, so it is sampled unsynchronised.
  assign frame_evt = ready_s2_q & ~ready_s3_q;

  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  rx_cnt_q;
  logic              ovf_q;
  logic [15:0]       frame_cnt_q;
  logic              rx_full, rx_pop, rx_push, rx_drop;

  assign rx_full = (rx_cnt_q == CNT_W'(RX_DEPTH));
  assign rx_pop  = rx_valid & rx_ready;
  assign rx_push = frame_evt & (~rx_full | rx_pop);
  assign rx_drop = frame_evt & rx_full & ~rx_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rx_cnt_q    <= '0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (rx_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rx_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + CNT_W'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - CNT_W'(1);
        default: rx_cnt_q <= rx_cnt_q;
      endcase
      ovf_q <= rx_drop | (ovf_q & ~ovf_clr);
      if (frame_evt) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // NOTE: queue storage has no reset; rx_valid is derived from the reset count and masks stale entries.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[wr_ptr_q] <= spi_data_in;
  end

  assign rx_valid    = (rx_cnt_q != '0);
  assign rx_data     = rx_mem_q[rd_ptr_q];
  assign rx_overflow = ovf_q;
  assign frame_cnt   = frame_cnt_q;

  tx_state_e         state_q;
  logic [DATA_W-1:0] data_out_q;
  logic [N_REQ-1:0]  req_ready_q;
  logic [N_REQ-1:0]  arb_grant;
  logic [ARB_W-1:0]  arb_idx;
  logic              arb_any, load_opp;
  logic [PAY_W-1:0]  pay_arr [N_REQ];
  logic [DATA_W-1:0] tx_word;

  for (genvar g = 0; g < N_REQ; g++) begin : g_pay
    assign pay_arr[g] = req_data[g*PAY_W +: PAY_W];
  end

  // While the bus is idle an empty slot may be filled at any time; otherwise only at frame boundaries.
  assign load_opp = (state_q == EMPTY) ? (frame_evt | cs_s2_q) : frame_evt;
  assign tx_word  = DATA_W'(make_tx_word(ID_W'(arb_idx), MAX_W'(pay_arr[arb_idx]), DATA_W));

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_valid),
    .advance_i (load_opp),
    .grant_o   (arb_grant),
    .idx_o     (arb_idx),
    .any_o     (arb_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      data_out_q  <= IDLE_WORD;
      req_ready_q <= '0;
    end else begin
      req_ready_q <= '0;
      if (load_opp) begin
        if (arb_any) begin
          data_out_q  <= tx_word;
          req_ready_q <= arb_grant;
          state_q     <= LOADED;
        end else begin
          case (state_q)
            LOADED: begin
              data_out_q <= IDLE_WORD;
              state_q    <= EMPTY;
            end
            default: state_q <= EMPTY;
          endcase
        end
      end
    end
  end

  assign spi_data_out = data_out_q;
  assign req_ready    = req_ready_q;

endmodule

// File: tb/tb_spi_link_ctrl.sv
// Randomised bench for spi_link_ctrl: a cycle-level reference model compared every cycle, plus literal anchors.
module tb_spi_link_ctrl;

  localparam int DATA_W   = 64;
  localparam int N_REQ    = 4;
  localparam int RX_DEPTH = 4;
  localparam int PAY_W    = 56;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [DATA_W-1:0]       spi_data_in;
  logic                    spi_ready;
  logic                    spi_cs;
  logic [DATA_W-1:0]       spi_data_out;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*PAY_W-1:0]  req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    rx_valid;
  logic [DATA_W-1:0]       rx_data;
  logic                    rx_ready;
  logic                    rx_overflow;
  logic                    ovf_clr;
  logic [15:0]             frame_cnt;
  logic [PAY_W-1:0]        pay [N_REQ];

  always #5 clk = ~clk;

  assign req_data = {pay[3], pay[2], pay[1], pay[0]};

  spi_link_ctrl #(.DATA_W(DATA_W), .N_REQ(N_REQ), .RX_DEPTH(RX_DEPTH), .IDLE_WORD(64'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_data_in  (spi_data_in),
    .spi_ready    (spi_ready),
    .spi_cs       (spi_cs),
    .spi_data_out (spi_data_out),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_overflow  (rx_overflow),
    .ovf_clr      (ovf_clr),
    .frame_cnt    (frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs seen at a clock edge take effect two edges later; a frame is a 0->1 of spi_ready.
  logic [63:0] rx_q[$];
  logic [63:0] m_word;
  logic [3:0]  m_ready;
  logic [15:0] m_cnt;
  bit          m_ovf, m_loaded;
  int          m_ptr;
  bit          r1, r2, r3, c1, c2;
  bit          m_evt, m_cs, m_pop, m_opp, m_newovf;
  int          m_g;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q.delete();
      m_word = '0; m_ready = '0; m_cnt = '0; m_ovf = 0; m_loaded = 0; m_ptr = 0;
      r1 = 0; r2 = 0; r3 = 0; c1 = 1; c2 = 1;
    end else begin
      m_evt = r2 && !r3;
      m_cs  = c2;
      r3 = r2; r2 = r1; r1 = spi_ready;
      c2 = c1; c1 = spi_cs;

      m_pop = rx_ready && (rx_q.size() > 0);
      if (m_pop) void'(rx_q.pop_front());
      m_newovf = 0;
      if (m_evt) begin
        m_cnt++;
        if (rx_q.size() < RX_DEPTH) rx_q.push_back(spi_data_in);
        else m_newovf = 1;
      end
      if (m_newovf) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;

      m_ready = '0;
      m_opp   = m_loaded ? m_evt : (m_evt || m_cs);
      if (m_opp) begin
        m_g = -1;
        for (int k = 0; k < N_REQ; k++)
          if (m_g < 0 && req_valid[(m_ptr + k) % N_REQ]) m_g = (m_ptr + k) % N_REQ;
        if (m_g >= 0) begin
          m_word   = {8'h80 | 8'(m_g), pay[m_g]};
          m_ready  = 4'(1 << m_g);
          m_ptr    = (m_g + 1) % N_REQ;
          m_loaded = 1;
        end else if (m_loaded) begin
          m_word   = '0;
          m_loaded = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("spi_data_out", spi_data_out, m_word);
      check("req_ready", 64'(req_ready), 64'(m_ready));
      check("rx_valid", 64'(rx_valid), 64'(rx_q.size() > 0));
      if (rx_q.size() > 0) check("rx_data", rx_data, rx_q[0]);
      check("rx_overflow", 64'(rx_overflow), 64'(m_ovf));
      check("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
    end
  end

  logic [3:0] g_log[$];
  logic [3:0] id_log[$];
  always @(negedge clk) begin
    if (req_ready != '0) begin
      g_log.push_back(req_ready);
      id_log.push_back(spi_data_out[59:56]);
    end
  end

  task automatic at_phase();
    @(posedge clk);
    #($urandom_range(1, 9));
  endtask

  task automatic do_reset();
    at_phase();
    rst_n = 1'b0; spi_ready = 1'b0; spi_cs = 1'b1;
    req_valid = '0; rx_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    at_phase();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_frame(input logic [63:0] d);
    at_phase();
    spi_data_in = d;
    spi_cs      = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #($urandom_range(1, 9));
    spi_ready = 1'b1;
    repeat (4) @(posedge clk);
    #($urandom_range(1, 9));
    spi_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic rand_pay();
    for (int i = 0; i < N_REQ; i++) pay[i] = {24'($urandom), $urandom};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int sz;
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; spi_ready = 1'b0; spi_cs = 1'b1; spi_data_in = '0;
    req_valid = '0; rx_ready = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < N_REQ; i++) pay[i] = '0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;

    // Reset state with bus idle and no requesters.
    do_reset();
    @(negedge clk);
    check("t1_data_out", spi_data_out, 64'h0);
    check("t1_req_ready", 64'(req_ready), 64'h0);
    check("t1_rx_valid", 64'(rx_valid), 64'h0);
    check("t1_overflow", 64'(rx_overflow), 64'h0);
    check("t1_frame_cnt", 64'(frame_cnt), 64'h0);

    // Single requester loaded while the bus is idle.
    pay[2]    = 56'hA5;
    req_valid = 4'b0100;
    k = 0;
    while (req_ready == '0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("t2_latency", 64'(k), 64'd1);
    check("t2_req_ready", 64'(req_ready), 64'h4);
    check("t2_data_out", spi_data_out, 64'h82000000000000A5);
    check("t2_loaded", 64'(spi_data_out[63]), 64'h1);
    req_valid = '0;
    @(negedge clk);
    check("t2_pulse_end", 64'(req_ready), 64'h0);

    // Round-robin over all requesters across five frames.
    do_reset();
    at_phase();
    spi_cs = 1'b0;
    repeat (4) @(posedge clk);
    rand_pay();
    g_log.delete();
    id_log.delete();
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) send_frame(64'(f + 100));
    req_valid = '0;
    check("t3_grant_count", 64'(g_log.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check("t3_grant", 64'(i < g_log.size() ? g_log[i] : 4'h0), 64'(1 << exp_g[i]));
      check("t3_id", 64'(i < id_log.size() ? id_log[i] : 4'hF), 64'(exp_g[i]));
    end

    // Queue fills, fifth frame dropped, then drained in order and overflow cleared.
    do_reset();
    for (int v = 1; v <= 5; v++) send_frame(64'(v));
    repeat (3) @(negedge clk);
    check("t4_overflow", 64'(rx_overflow), 64'h1);
    check("t4_frame_cnt", 64'(frame_cnt), 64'd5);
    for (int v = 1; v <= 4; v++) begin
      @(negedge clk);
      check("t4_rx_valid", 64'(rx_valid), 64'h1);
      check("t4_rx_data", rx_data, 64'(v));
      rx_ready = 1'b1;
    end
    @(negedge clk);
    rx_ready = 1'b0;
    check("t4_drained", 64'(rx_valid), 64'h0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 64'(rx_overflow), 64'h0);

    // Randomised traffic with asynchronous frame pulses and idle gaps.
    do_reset();
    for (int f = 0; f < 40; f++) begin
      at_phase();
      rand_pay();
      req_valid = 4'($urandom);
      rx_ready  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        ovf_clr = 1'b1;
        at_phase();
        ovf_clr = 1'b0;
      end
      send_frame({$urandom, $urandom});
      if ($urandom_range(0, 1) == 1) begin
        spi_cs = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
      end
    end
    repeat (4) @(negedge clk);
    check("t5_frame_cnt", 64'(frame_cnt), 64'd40);

    // Reset in the middle of a frame while a word is loaded.
    do_reset();
    at_phase();
    spi_cs    = 1'b0;
    pay[0]    = 56'h123;
    req_valid = 4'b0001;
    repeat (4) @(posedge clk);
    req_valid = '0;
    @(negedge clk);
    check("t6_loaded", spi_data_out, 64'h8000000000000123);
    sz = g_log.size();
    at_phase();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_idle_word", spi_data_out, 64'h0);
      check("t6_no_ack", 64'(req_ready), 64'h0);
    end
    at_phase();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6_no_grant", 64'(g_log.size()), 64'(sz));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
